// File: rtl/obc_check_pkg.sv
// Shared definitions for the on-board-computer challenge/response check.
// Both the responder and the supervisor side import this package so the
// answer function and the question/answer type stay in one place.
package obc_check_pkg;

    typedef logic [3:0] nibble_t;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        WAIT    = 2'd1,
        RESPOND = 2'd2
    } obc_state_t;

    // Bit flipped in the answer when a test fault is injected at pop time.
    localparam nibble_t FAULT_MASK = 4'b0001;

    // Each answer bit folds a question bit with its lower neighbour; bit 0 is inverted.
    function automatic nibble_t obc_answer(input nibble_t q);
        return {q[2] ^ q[3], q[1] ^ q[2], q[0] ^ q[1], ~q[0]};
    endfunction

endpackage

// File: rtl/question_fifo.sv
// Small synchronous FIFO buffering incoming questions.
// The head entry is visible on o_data without a read latency, so the
// responder can pop and use the question on the same edge.
module question_fifo #(
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       i_flush,
    input  logic                       i_push,
    input  logic [3:0]                 i_data,
    input  logic                       i_pop,
    output logic [3:0]                 o_data,
    output logic                       o_full,
    output logic                       o_empty,
    output logic [$clog2(DEPTH):0]     o_count
);
    import obc_check_pkg::*;

    localparam int PTR_W = $clog2(DEPTH);
    localparam logic [PTR_W:0] FULL_COUNT = (PTR_W + 1)'(DEPTH);

    nibble_t          r_mem [DEPTH];
    logic [PTR_W-1:0] r_wrPtr;
    logic [PTR_W-1:0] r_rdPtr;
    logic [PTR_W:0]   r_count;

    logic w_doPush;
    logic w_doPop;

    assign o_full   = (r_count == FULL_COUNT);
    assign o_empty  = (r_count == '0);
    assign o_count  = r_count;
    assign o_data   = r_mem[r_rdPtr];

    // Requests that would overflow or underflow are dropped here as a last guard.
    assign w_doPush = i_push && !o_full;
    assign w_doPop  = i_pop && !o_empty;

    // Storage array; stale contents are harmless because pointers define validity.
    always_ff @(posedge clk) begin
        if (w_doPush && !reset && !i_flush) begin
            r_mem[r_wrPtr] <= i_data;
        end
    end

    // Pointer and occupancy bookkeeping; reset and flush both empty the queue.
    always_ff @(posedge clk) begin
        if (reset || i_flush) begin
            r_wrPtr <= '0;
            r_rdPtr <= '0;
            r_count <= '0;
        end else begin
            if (w_doPush) begin
                r_wrPtr <= r_wrPtr + 1'b1;
            end
            if (w_doPop) begin
                r_rdPtr <= r_rdPtr + 1'b1;
            end
            case ({w_doPush, w_doPop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/obc_responder.sv
// Challenge/response responder: buffers supervisor questions, waits a fixed
// latency after taking each one, then presents the computed answer until the
// supervisor accepts it. Halt flushes everything but keeps the answer tally.
module obc_responder #(
    parameter int FIFO_DEPTH   = 4,
    parameter int RESP_LATENCY = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] question,
    input  logic       question_valid,
    output logic       question_ready,
    output logic [3:0] answer,
    output logic       answer_valid,
    input  logic       answer_ready,
    input  logic       fault_inject,
    input  logic       halt,
    output logic       busy,
    output logic [7:0] answer_count
);
    import obc_check_pkg::*;

    localparam int         CNT_W   = $clog2(FIFO_DEPTH) + 1;
    localparam logic [3:0] LATENCY = 4'(RESP_LATENCY);

    obc_state_t r_state;
    logic [3:0] r_latency;
    nibble_t    r_pending;
    nibble_t    r_answer;
    logic       r_answerValid;
    logic [7:0] r_answerCount;
    logic       r_halted;

    logic             w_push;
    logic             w_pop;
    nibble_t          w_fifoData;
    logic             w_full;
    logic             w_empty;
    logic [CNT_W-1:0] w_fifoCount;
    nibble_t          w_answerNext;

    // Ready depends only on registered state; r_halted keeps it low while halt is held.
    assign question_ready = !w_full && !r_halted;
    assign w_push         = question_valid && question_ready;
    assign w_pop          = (r_state == IDLE) && !w_empty && !halt;

    // Fault injection is only looked at here, i.e. at the pop cycle.
    assign w_answerNext   = obc_answer(w_fifoData) ^ (fault_inject ? FAULT_MASK : 4'b0000);

    assign answer         = r_answer;
    assign answer_valid   = r_answerValid;
    assign answer_count   = r_answerCount;
    assign busy           = (r_state != IDLE) || (w_fifoCount != '0);

    question_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_questionFifo (
        .clk     (clk),
        .reset   (reset),
        .i_flush (halt),
        .i_push  (w_push),
        .i_data  (question),
        .i_pop   (w_pop),
        .o_data  (w_fifoData),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_count (w_fifoCount)
    );

    // Remember that halt was seen so question_ready drops on the edge after halt rises.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_halted <= 1'b0;
        end else begin
            r_halted <= halt;
        end
    end

    // Responder FSM: pop a question, count down the latency, then hold the answer until accepted.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state       <= IDLE;
            r_latency     <= '0;
            r_pending     <= '0;
            r_answer      <= '0;
            r_answerValid <= 1'b0;
            r_answerCount <= '0;
        end else if (halt) begin
            r_state       <= IDLE;
            r_latency     <= '0;
            r_answer      <= '0;
            r_answerValid <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (!w_empty) begin
                        r_pending <= w_answerNext;
                        r_latency <= LATENCY;
                        if (LATENCY == 4'd0) begin
                            r_state       <= RESPOND;
                            r_answer      <= w_answerNext;
                            r_answerValid <= 1'b1;
                        end else begin
                            r_state <= WAIT;
                        end
                    end
                end
                WAIT: begin
                    if (r_latency == 4'd0) begin
                        r_state       <= RESPOND;
                        r_answer      <= r_pending;
                        r_answerValid <= 1'b1;
                    end else begin
                        r_latency <= r_latency - 1'b1;
                    end
                end
                RESPOND: begin
                    if (answer_ready) begin
                        r_state       <= IDLE;
                        r_answer      <= '0;
                        r_answerValid <= 1'b0;
                        r_answerCount <= r_answerCount + 1'b1;
                    end
                end
                default: begin
                    r_state       <= IDLE;
                    r_answer      <= '0;
                    r_answerValid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_obc_responder.sv
// Directed self-checking bench for obc_responder with a scoreboard queue:
// expected answers are queued when a question is accepted and compared in
// order when the responder presents them.
module tb_obc_responder;

    logic       clk = 1'b0;
    logic       reset;
    logic [3:0] question;
    logic       question_valid;
    logic       question_ready;
    logic [3:0] answer;
    logic       answer_valid;
    logic       answer_ready;
    logic       fault_inject;
    logic       halt;
    logic       busy;
    logic [7:0] answer_count;

    int         total = 0;
    int         bad = 0;
    int         expCount = 0;
    logic [3:0] expQ [$];

    obc_responder #(
        .FIFO_DEPTH   (4),
        .RESP_LATENCY (2)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .question       (question),
        .question_valid (question_valid),
        .question_ready (question_ready),
        .answer         (answer),
        .answer_valid   (answer_valid),
        .answer_ready   (answer_ready),
        .fault_inject   (fault_inject),
        .halt           (halt),
        .busy           (busy),
        .answer_count   (answer_count)
    );

    // Free-running clock, 10 time units per period.
    always #5 clk = ~clk;

    // Independent reference for the answer bits.
    function automatic logic [3:0] refAnswer(input logic [3:0] q);
        logic [3:0] a;
        a[0] = ~q[0];
        a[1] = q[0] ^ q[1];
        a[2] = q[1] ^ q[2];
        a[3] = q[2] ^ q[3];
        return a;
    endfunction

    // Advance one clock and settle just after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Offer a question until accepted, then queue the answer we expect for it.
    task automatic applyStimulus(input logic [3:0] q, input logic [3:0] expAns);
        int n;
        n = 0;
        question       = q;
        question_valid = 1'b1;
        while (!question_ready && n < 50) begin
            tick();
            n++;
        end
        checkOutput("readyTimeout", question_ready, 1);
        tick();
        question_valid = 1'b0;
        question       = 4'd0;
        expQ.push_back(expAns);
    endtask

    task automatic waitValid(output int n);
        n = 0;
        while (!answer_valid && n < 50) begin
            tick();
            n++;
        end
        checkOutput("answerValidTimeout", answer_valid, 1);
    endtask

    // Wait for an answer, compare it with the scoreboard head, then accept it.
    task automatic collectAnswer(input string tag);
        int         n;
        logic [3:0] exp;
        waitValid(n);
        checkOutput("scoreboardUnderflow", (expQ.size() == 0), 0);
        exp = (expQ.size() != 0) ? expQ.pop_front() : 4'd0;
        checkOutput(tag, answer, exp);
        answer_ready = 1'b1;
        tick();
        answer_ready = 1'b0;
        expCount = (expCount + 1) % 256;
        checkOutput("answerCount", answer_count, expCount);
        checkOutput("validDrop", answer_valid, 0);
        checkOutput("answerZeroWhenIdle", answer, 0);
    endtask

    initial begin
        int         n;
        logic [3:0] held;
        logic       sawValid;
        logic [3:0] q;

        reset          = 1'b1;
        question       = 4'd0;
        question_valid = 1'b0;
        answer_ready   = 1'b0;
        fault_inject   = 1'b0;
        halt           = 1'b0;
        tick();
        tick();
        checkOutput("rstValid", answer_valid, 0);
        checkOutput("rstAnswer", answer, 0);
        checkOutput("rstBusy", busy, 0);
        checkOutput("rstCount", answer_count, 0);
        reset = 1'b0;
        tick();
        checkOutput("rstReady", question_ready, 1);

        // Single questions with latency measurement.
        applyStimulus(4'b0000, 4'b0001);
        checkOutput("busyAfterAccept", busy, 1);
        waitValid(n);
        checkOutput("latency0000", n, 4);
        collectAnswer("ans0000");
        applyStimulus(4'b1010, 4'b1111);
        waitValid(n);
        checkOutput("latency1010", n, 4);
        collectAnswer("ans1010");
        applyStimulus(4'b1111, 4'b0000);
        waitValid(n);
        checkOutput("latency1111", n, 4);
        collectAnswer("ans1111");
        applyStimulus(4'b0101, 4'b1110);
        waitValid(n);
        checkOutput("latency0101", n, 4);
        collectAnswer("ans0101");

        // Backpressure: the first question is drained into the FSM, so five fit before full.
        for (int i = 0; i < 5; i++) begin
            q = 4'(i * 3 + 1);
            applyStimulus(q, refAnswer(q));
            if (i == 3) checkOutput("readyAfter4th", question_ready, 1);
        end
        checkOutput("readyLowWhenFull", question_ready, 0);
        question       = 4'b1001;
        question_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            checkOutput("readyHeldLow", question_ready, 0);
        end
        question_valid = 1'b0;
        waitValid(n);
        held = answer;
        tick();
        tick();
        tick();
        checkOutput("answerStable", answer, held);
        checkOutput("validHeld", answer_valid, 1);
        for (int i = 0; i < 5; i++) begin
            collectAnswer("backpressureOrder");
        end
        sawValid = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick();
            sawValid = sawValid | answer_valid;
        end
        checkOutput("heldQuestionDropped", sawValid, 0);
        checkOutput("idleAfterDrain", busy, 0);

        // Fault injection only matters at the pop edge.
        fault_inject = 1'b1;
        applyStimulus(4'b0000, 4'b0000);
        tick();
        fault_inject = 1'b0;
        collectAnswer("faultAnswer");
        applyStimulus(4'b0000, 4'b0001);
        collectAnswer("cleanAfterFault");
        applyStimulus(4'b0011, refAnswer(4'b0011));
        tick();
        fault_inject = 1'b1;
        collectAnswer("faultAfterPopIgnored");
        fault_inject = 1'b0;

        // Halt while responding with two questions queued; halt beats answer_ready.
        applyStimulus(4'b0001, refAnswer(4'b0001));
        applyStimulus(4'b0010, refAnswer(4'b0010));
        applyStimulus(4'b0100, refAnswer(4'b0100));
        waitValid(n);
        checkOutput("busyBeforeHalt", busy, 1);
        halt         = 1'b1;
        answer_ready = 1'b1;
        tick();
        answer_ready = 1'b0;
        checkOutput("haltValid", answer_valid, 0);
        checkOutput("haltAnswer", answer, 0);
        checkOutput("haltCount", answer_count, expCount);
        checkOutput("haltFlushed", busy, 0);
        checkOutput("haltReady", question_ready, 0);
        tick();
        checkOutput("haltReadyHeld", question_ready, 0);
        halt = 1'b0;
        expQ.delete();
        sawValid = 1'b0;
        for (int i = 0; i < 12; i++) begin
            tick();
            sawValid = sawValid | answer_valid;
        end
        checkOutput("noAnswerAfterHalt", sawValid, 0);
        checkOutput("readyAfterHalt", question_ready, 1);

        // Reset in the middle of WAIT discards the pending answer.
        applyStimulus(4'b0110, refAnswer(4'b0110));
        tick();
        tick();
        reset = 1'b1;
        tick();
        checkOutput("midWaitRstValid", answer_valid, 0);
        checkOutput("midWaitRstAnswer", answer, 0);
        checkOutput("midWaitRstBusy", busy, 0);
        checkOutput("midWaitRstCount", answer_count, 0);
        reset = 1'b0;
        expQ.delete();
        expCount = 0;
        tick();
        checkOutput("midWaitRstReady", question_ready, 1);
        sawValid = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick();
            sawValid = sawValid | answer_valid;
        end
        checkOutput("noAnswerAfterReset", sawValid, 0);

        // 256 handshakes from zero wrap the counter back to zero.
        for (int i = 0; i < 256; i++) begin
            q = 4'($urandom_range(0, 15));
            applyStimulus(q, refAnswer(q));
            collectAnswer("wrapAnswer");
            if (i == 254) checkOutput("count255", answer_count, 255);
        end
        checkOutput("wrapToZero", answer_count, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Last-resort guard so the run can never hang.
    initial begin
        #500000;
        $display("[TB] FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
